mult_div_thirtytwo_bit: RTL and testbench
=========================================

# mult_div_thirtytwo_bit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers. It serves MULT, MULTU, DIV, DIVU, MTHI and MTLO, and drives HI/LO for MFHI and MFLO. It takes the same rs/rt operand pair (inpA, inpB) from the register file that feeds the 32-bit logic units. Its HI/LO outputs feed the writeback result mux beside the ALU result.

## Interface
- Parameters: none; width fixed at 32 bits.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- inpA  input  32  rs operand (multiplicand / dividend).
- inpB  input  32  rt operand (multiplier / divisor).
- hiWrite  input  1  MTHI: HI <= wrData.
- loWrite  input  1  MTLO: LO <= wrData.
- wrData  input  32  data for MTHI/MTLO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse when HI/LO updated by an operation.
- hi  output  32  HI register.
- lo  output  32  LO register.

## Operation
- Reset values: hi=0, lo=0, busy=0, done=0, state IDLE, iteration count=0.
- States:
  - IDLE -> RUN on start.
  - RUN holds for 32 iterations, one per cycle, then returns to IDLE, writing HI/LO and pulsing done.
- Operand capture at start:
  - inpA, inpB and op are registered; later changes are ignored.
  - Signed ops (MULT, DIV) work on magnitudes and record the operand signs.
- Multiply: radix-2 shift-add into a 64-bit accumulator. If signs differ, the product is two's-complement negated. HI=product[63:32], LO=product[31:0].
- Divide: restoring division, one quotient bit per cycle. LO=quotient, HI=remainder.
  - Signed: quotient negated if signs differ; remainder takes the dividend's sign (truncation toward zero).
  - Divide by zero, any op: completes in normal time with LO=32'hFFFFFFFF, HI=inpA as captured.
- MTHI/MTLO: honoured only in IDLE with start=0, written at the next edge. If hiWrite and loWrite are both high, both registers take wrData.
- Ignored inputs:
  - start while busy.
  - hiWrite/loWrite while busy.
  - hiWrite/loWrite asserted with start in IDLE (start wins).
- hi/lo hold their previous values for the whole RUN. Readers stall on busy.

## Timing
- Edge E0 samples start=1 in IDLE; busy=1 after E0.
- Edges E1..E32 perform iterations 1..32.
- At E32: hi/lo updated, busy->0, done->1. done falls at E33.
- Start-to-result latency: 32 cycles after the launching edge.
- Back-to-back operation: start may be asserted in the cycle where done=1 (IDLE); the new run begins at E33.
- MTHI/MTLO latency: 1 edge.
- Reset mid-operation: asynchronous abort. busy=0, done=0, hi=lo=0 immediately; no done pulse for the aborted operation.
- Outputs are registers only; no combinational path from inputs to outputs.

## Configuration
- MULDIV_DIV_EN defined: full behaviour above.
- MULDIV_DIV_EN undefined: divider datapath is not built.
  - start with op[1]=1 enters no RUN and leaves busy=0.
  - done pulses for one cycle after the sampling edge; hi/lo are unchanged.
  - Multiply, MTHI and MTLO behave identically to the defined case.

## Test plan
- MULTU 32'hFFFFFFFF x 32'hFFFFFFFF -> busy for 32 cycles, then done; HI=32'hFFFFFFFE, LO=32'h00000001.
- MULT -3 (32'hFFFFFFFD) x 5 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFF1. Also DIV -7 / 2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- DIVU 32'h00001234 / 0 -> after 32 cycles LO=32'hFFFFFFFF, HI=32'h00001234. With MULDIV_DIV_EN undefined: done after 1 cycle, HI/LO unchanged.
- Start MULTU 7 x 9, then pulse start with op=DIVU and assert hiWrite at cycle 5 -> both ignored; final HI=0, LO=32'h0000003F, single done pulse.
- MTLO wrData=32'hCAFEF00D in IDLE -> LO=32'hCAFEF00D next edge, HI unchanged, done stays 0.
- Assert reset at cycle 10 of MULTU 32'h10000 x 32'h10000 -> busy=0, hi=lo=0 immediately, no done. A new MULTU 2 x 3 afterwards -> LO=6, HI=0.

Source files
------------

// File: rtl/mult_div_thirtytwo_bit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Define MULDIV_DIV_EN to build the restoring divider; without it only multiply and MTHI/MTLO run.
module mult_div_thirtytwo_bit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] inpA,
    input  logic [31:0] inpB,
    input  logic        hiWrite,
    input  logic        loWrite,
    input  logic [31:0] wrData,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dbg_state
);
    // Handshake: start is taken only while busy=0; busy stays high for the
    // 32 iterations and done pulses exactly once in the cycle HI/LO change.
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state;
    logic [4:0]  count;
    logic        neg_res;
    logic [31:0] mag_m;
    logic [63:0] acc, acc_next, prod;
    logic [32:0] mul_sum;
    logic        a_neg_in, b_neg_in;
    logic [31:0] a_mag_in, b_mag_in;
    logic [31:0] res_hi, res_lo;
`ifdef MULDIV_DIV_EN
    logic        is_div, neg_a, div_zero;
    logic [32:0] div_shift, div_diff;
`endif

    assign dbg_state = state;

    always_comb begin
        a_neg_in = ~op[0] & inpA[31];
        b_neg_in = ~op[0] & inpB[31];
        a_mag_in = a_neg_in ? (~inpA + 32'd1) : inpA;
        b_mag_in = b_neg_in ? (~inpB + 32'd1) : inpB;
    end

    // acc holds {partial product, remaining multiplier} when multiplying and
    // {partial remainder, remaining dividend / quotient bits} when dividing.
    always_comb begin
        mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_m} : 33'd0);
        acc_next = {mul_sum, acc[31:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {acc[63:32], acc[31]};
        div_diff  = div_shift - {1'b0, mag_m};
        if (is_div) begin
            if (!div_diff[32])
                acc_next = {div_diff[31:0], acc[30:0], 1'b1};
            else
                acc_next = {div_shift[31:0], acc[30:0], 1'b0};
        end
`endif
    end

    always_comb begin
        prod   = neg_res ? (~acc_next + 64'd1) : acc_next;
        res_hi = prod[63:32];
        res_lo = prod[31:0];
`ifdef MULDIV_DIV_EN
        // A zero divisor naturally leaves all-ones quotient and the dividend as remainder.
        if (is_div) begin
            res_hi = neg_a ? (~acc_next[63:32] + 32'd1) : acc_next[63:32];
            if (div_zero)
                res_lo = 32'hFFFFFFFF;
            else
                res_lo = neg_res ? (~acc_next[31:0] + 32'd1) : acc_next[31:0];
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= 5'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            acc     <= 64'd0;
            mag_m   <= 32'd0;
            neg_res <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div   <= 1'b0;
            neg_a    <= 1'b0;
            div_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
`ifdef MULDIV_DIV_EN
                        state    <= RUN;
                        busy     <= 1'b1;
                        count    <= 5'd0;
                        neg_res  <= a_neg_in ^ b_neg_in;
                        is_div   <= op[1];
                        neg_a    <= a_neg_in;
                        div_zero <= (inpB == 32'd0);
                        if (op[1]) begin
                            mag_m <= b_mag_in;
                            acc   <= {32'd0, a_mag_in};
                        end else begin
                            mag_m <= a_mag_in;
                            acc   <= {32'd0, b_mag_in};
                        end
`else
                        if (op[1]) begin
                            done <= 1'b1;
                        end else begin
                            state   <= RUN;
                            busy    <= 1'b1;
                            count   <= 5'd0;
                            neg_res <= a_neg_in ^ b_neg_in;
                            mag_m   <= a_mag_in;
                            acc     <= {32'd0, b_mag_in};
                        end
`endif
                    end else begin
                        if (hiWrite) hi <= wrData;
                        if (loWrite) lo <= wrData;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= res_hi;
                        lo    <= res_lo;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_thirtytwo_bit.sv
// Bench for mult_div_thirtytwo_bit: directed cases plus randomized ops against a
// plain-arithmetic reference model; follows MULDIV_DIV_EN for divide expectations.
module tb_mult_div_thirtytwo_bit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] inpA, inpB;
    logic        hiWrite, loWrite;
    logic [31:0] wrData;
    logic        busy, done;
    logic [31:0] hi, lo;
    logic        dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];
    logic [31:0] model_hi, model_lo;

    mult_div_thirtytwo_bit dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .inpA(inpA), .inpB(inpB), .hiWrite(hiWrite), .loWrite(loWrite),
        .wrData(wrData), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: 64-bit arithmetic straight from the MIPS definitions.
    task automatic ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] eh, output logic [31:0] el);
        longint sa, sb, q, r;
        logic [63:0] p;
        eh = model_hi;
        el = model_lo;
        case (o)
            2'b00: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p  = 64'(sa * sb);
                eh = p[63:32]; el = p[31:0];
            end
            2'b01: begin
                p  = {32'd0, a} * {32'd0, b};
                eh = p[63:32]; el = p[31:0];
            end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 32'd0) begin
                    eh = a; el = 32'hFFFFFFFF;
                end else begin
                    if (o == 2'b10) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                    end else begin
                        sa = longint'({32'd0, a});
                        sb = longint'({32'd0, b});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    eh = 32'(r); el = 32'(q);
                end
`endif
            end
        endcase
    endtask

    task automatic sb_check(input string tag);
        logic [63:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        check(tag, {hi, lo}, e);
        model_hi = e[63:32];
        model_lo = e[31:0];
    endtask

    // Launch one operation; inj_cyc injects ignored start/hiWrite, abort_cyc resets mid-run.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int inj_cyc, input int abort_cyc, input bit b2b);
        logic [31:0] eh, el;
        int cyc;
        ref_op(o, a, b, eh, el);
        exp_q.push_back({eh, el});
        start = 1'b1; op = o; inpA = a; inpB = b;
        hiWrite = 1'b0; loWrite = 1'b0;
        tick();
        start = 1'b0; op = 2'($urandom_range(0, 3));
        inpA = $urandom; inpB = $urandom;
`ifndef MULDIV_DIV_EN
        if (o[1]) begin
            check("nodiv_busy", {63'd0, busy}, 64'd0);
            check("nodiv_done", {63'd0, done}, 64'd1);
            sb_check("nodiv_hilo");
            if (!b2b) begin
                tick();
                check("nodiv_done_fall", {63'd0, done}, 64'd0);
            end
            return;
        end
`endif
        check("busy_e0", {63'd0, busy}, 64'd1);
        check("done_low_e0", {63'd0, done}, 64'd0);
        cyc = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
            if (cyc == 16)
                check("hold_mid_run", {hi, lo}, {model_hi, model_lo});
            if (inj_cyc != 0 && cyc == inj_cyc) begin
                start = 1'b1; op = 2'b11; hiWrite = 1'b1; wrData = $urandom;
            end else if (inj_cyc != 0 && cyc == inj_cyc + 1) begin
                start = 1'b0; hiWrite = 1'b0;
            end
            if (abort_cyc != 0 && cyc == abort_cyc) begin
                reset = 1'b1;
                #1;
                check("abort_state", {28'd0, busy, done, dbg_state, 1'b0, hi, lo}, 64'd0);
                reset = 1'b0;
                void'(exp_q.pop_back());
                model_hi = 32'd0; model_lo = 32'd0;
                tick();
                check("abort_no_done", {63'd0, done}, 64'd0);
                return;
            end
        end
        check("latency", 64'(cyc), 64'd32);
        check("busy_at_done", {63'd0, busy}, 64'd0);
        sb_check("result");
        if (!b2b) begin
            tick();
            check("done_pulse", {63'd0, done}, 64'd0);
        end
    endtask

    task automatic mt(input logic hw, input logic lw, input logic [31:0] d);
        start = 1'b0; hiWrite = hw; loWrite = lw; wrData = d;
        tick();
        hiWrite = 1'b0; loWrite = 1'b0;
        if (hw) model_hi = d;
        if (lw) model_lo = d;
        check("mt_hilo", {hi, lo}, {model_hi, model_lo});
        check("mt_done", {63'd0, done}, 64'd0);
    endtask

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; inpA = 32'd0; inpB = 32'd0;
        hiWrite = 1'b0; loWrite = 1'b0; wrData = 32'd0;
        model_hi = 32'd0; model_lo = 32'd0;
        tick(); tick();
        check("reset_state", {29'd0, busy, done, dbg_state, hi}, 64'd0);
        check("reset_lo", {32'd0, lo}, 64'd0);
        reset = 1'b0;
        tick();

        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0);
        check("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);
        do_op(2'b00, 32'hFFFFFFFD, 32'd5, 0, 0, 0);
        check("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 0, 0, 0);
        do_op(2'b11, 32'h00001234, 32'd0, 0, 0, 0);
        mt(1'b0, 1'b1, 32'hCAFEF00D);
        check("mtlo_val", {32'd0, lo}, 64'h00000000_CAFEF00D);
        mt(1'b1, 1'b0, 32'h12345678);
        mt(1'b1, 1'b1, 32'h0BADBEEF);
        do_op(2'b01, 32'd7, 32'd9, 5, 0, 0);
        check("ignored_inputs", {hi, lo}, 64'h00000000_0000003F);
        do_op(2'b01, 32'h00010000, 32'h00010000, 0, 10, 0);
        do_op(2'b01, 32'd2, 32'd3, 0, 0, 1);
        do_op(2'b00, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
            do_op(2'($urandom_range(0, 3)), rand_val(), rand_val(), 0, 0,
                  1'($urandom_range(0, 1)));
        end
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
